// File: rtl/axil_slv_if.sv
// AXI4-Lite subordinate that bridges independent write and read channels onto
// a simple valid/ready local register-access port. All outputs are flops.
module axil_slv_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ALIGN_BITS = $clog2(STRB_WIDTH)
) (
  input  logic                  aclk,
  input  logic                  anreset,
  input  logic                  aenable,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [2:0]            i_awprot,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [2:0]            i_arprot,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic                  o_reg_wr_valid,
  output logic [ADDR_WIDTH-1:0] o_reg_wr_addr,
  output logic [DATA_WIDTH-1:0] o_reg_wr_data,
  output logic [STRB_WIDTH-1:0] o_reg_wr_strb,
  input  logic                  i_reg_wr_ready,
  input  logic                  i_reg_wr_err,
  output logic                  o_reg_rd_valid,
  output logic [ADDR_WIDTH-1:0] o_reg_rd_addr,
  input  logic                  i_reg_rd_ready,
  input  logic [DATA_WIDTH-1:0] i_reg_rd_data,
  input  logic                  i_reg_rd_err
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACCESS, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESP} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_WIDTH-1:0] wr_strb_q, wr_strb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  awready_q, wready_q, bvalid_q, reg_wr_valid_q;

  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  arready_q, rvalid_q, reg_rd_valid_q;

  logic aw_hs, w_hs, ar_hs;
  logic unused_prot;

  assign unused_prot = ^{i_awprot, i_arprot};
  assign aw_hs = awready_q & i_awvalid;
  assign w_hs  = wready_q & i_wvalid;
  assign ar_hs = arready_q & i_arvalid;

  // The decision to access or reject is taken on the edge that completes the
  // AW/W pair, so the local strobe appears the very next cycle.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          wr_addr_d = i_awaddr;
        end
        if (w_hs) begin
          w_held_d  = 1'b1;
          wr_data_d = i_wdata;
          wr_strb_d = i_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          if (wr_addr_d[ALIGN_BITS-1:0] == '0) begin
            w_state_d = W_ACCESS;
          end else begin
            w_state_d = W_RESP;
            bresp_d   = RESP_SLVERR;
          end
        end
      end
      W_ACCESS: begin
        if (i_reg_wr_ready) begin
          w_state_d = W_RESP;
          bresp_d   = i_reg_wr_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: begin
        if (bvalid_q && i_bready) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = RESP_OKAY;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_addr_d = i_araddr;
          if (i_araddr[ALIGN_BITS-1:0] == '0) begin
            r_state_d = R_ACCESS;
          end else begin
            r_state_d = R_RESP;
            rdata_d   = '0;
            rresp_d   = RESP_SLVERR;
          end
        end
      end
      R_ACCESS: begin
        if (i_reg_rd_ready) begin
          r_state_d = R_RESP;
          rdata_d   = i_reg_rd_data;
          rresp_d   = i_reg_rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_RESP: begin
        if (rvalid_q && i_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Handshake/valid flops are derived from next state so they stay registered.
  always_ff @(posedge aclk) begin
    if (!anreset) begin
      w_state_q      <= W_IDLE;
      aw_held_q      <= 1'b0;
      w_held_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_strb_q      <= '0;
      bresp_q        <= RESP_OKAY;
      awready_q      <= 1'b0;
      wready_q       <= 1'b0;
      bvalid_q       <= 1'b0;
      reg_wr_valid_q <= 1'b0;
      r_state_q      <= R_IDLE;
      rd_addr_q      <= '0;
      rdata_q        <= '0;
      rresp_q        <= RESP_OKAY;
      arready_q      <= 1'b0;
      rvalid_q       <= 1'b0;
      reg_rd_valid_q <= 1'b0;
    end else begin
      w_state_q      <= w_state_d;
      aw_held_q      <= aw_held_d;
      w_held_q       <= w_held_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_strb_q      <= wr_strb_d;
      bresp_q        <= bresp_d;
      awready_q      <= (w_state_d == W_IDLE) && aenable && !aw_held_d;
      wready_q       <= (w_state_d == W_IDLE) && aenable && !w_held_d;
      bvalid_q       <= (w_state_d == W_RESP);
      reg_wr_valid_q <= (w_state_d == W_ACCESS);
      r_state_q      <= r_state_d;
      rd_addr_q      <= rd_addr_d;
      rdata_q        <= rdata_d;
      rresp_q        <= rresp_d;
      arready_q      <= (r_state_d == R_IDLE) && aenable;
      rvalid_q       <= (r_state_d == R_RESP);
      reg_rd_valid_q <= (r_state_d == R_ACCESS);
    end
  end

  assign o_awready      = awready_q;
  assign o_wready       = wready_q;
  assign o_bresp        = bresp_q;
  assign o_bvalid       = bvalid_q;
  assign o_arready      = arready_q;
  assign o_rdata        = rdata_q;
  assign o_rresp        = rresp_q;
  assign o_rvalid       = rvalid_q;
  assign o_reg_wr_valid = reg_wr_valid_q;
  assign o_reg_wr_addr  = wr_addr_q;
  assign o_reg_wr_data  = wr_data_q;
  assign o_reg_wr_strb  = wr_strb_q;
  assign o_reg_rd_valid = reg_rd_valid_q;
  assign o_reg_rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_axil_slv_if.sv
// Directed bench for axil_slv_if: one task per scenario with inline checks
// against hand-computed expectations.
module tb_axil_slv_if;

  localparam int AW = 16;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          aclk = 1'b0;
  logic          anreset, aenable;
  logic [AW-1:0] i_awaddr, i_araddr;
  logic [2:0]    i_awprot, i_arprot;
  logic          i_awvalid, i_wvalid, i_bready, i_arvalid, i_rready;
  logic [DW-1:0] i_wdata, i_reg_rd_data;
  logic [SW-1:0] i_wstrb;
  logic          o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
  logic [1:0]    o_bresp, o_rresp;
  logic [DW-1:0] o_rdata, o_reg_wr_data;
  logic          o_reg_wr_valid, o_reg_rd_valid;
  logic [AW-1:0] o_reg_wr_addr, o_reg_rd_addr;
  logic [SW-1:0] o_reg_wr_strb;
  logic          i_reg_wr_ready, i_reg_wr_err, i_reg_rd_ready, i_reg_rd_err;

  int vectors = 0;
  int errors  = 0;

  always #5 aclk = ~aclk;

  axil_slv_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .anreset(anreset), .aenable(aenable),
    .i_awaddr(i_awaddr), .i_awprot(i_awprot), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_araddr(i_araddr), .i_arprot(i_arprot), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready),
    .o_reg_wr_valid(o_reg_wr_valid), .o_reg_wr_addr(o_reg_wr_addr),
    .o_reg_wr_data(o_reg_wr_data), .o_reg_wr_strb(o_reg_wr_strb),
    .i_reg_wr_ready(i_reg_wr_ready), .i_reg_wr_err(i_reg_wr_err),
    .o_reg_rd_valid(o_reg_rd_valid), .o_reg_rd_addr(o_reg_rd_addr),
    .i_reg_rd_ready(i_reg_rd_ready), .i_reg_rd_data(i_reg_rd_data), .i_reg_rd_err(i_reg_rd_err)
  );

  // Outputs are observed 1ns after the rising edge, inputs changed at the same point.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    anreset = 1'b0; aenable = 1'b1;
    i_awaddr = '0; i_araddr = '0; i_awprot = '0; i_arprot = '0;
    i_awvalid = 0; i_wvalid = 0; i_bready = 0; i_arvalid = 0; i_rready = 0;
    i_wdata = '0; i_wstrb = '0; i_reg_rd_data = '0;
    i_reg_wr_ready = 0; i_reg_wr_err = 0; i_reg_rd_ready = 0; i_reg_rd_err = 0;
    repeat (3) tick();
    vectors++;
    if ({o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_reg_wr_valid, o_reg_rd_valid} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshakes: got %b expected 0000000",
               {o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_reg_wr_valid, o_reg_rd_valid});
    end
    vectors++;
    if ({o_bresp, o_rresp, o_rdata, o_reg_wr_addr, o_reg_wr_data, o_reg_wr_strb, o_reg_rd_addr} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: bresp=%b rresp=%b rdata=%h waddr=%h wdata=%h wstrb=%h raddr=%h expected all 0",
               o_bresp, o_rresp, o_rdata, o_reg_wr_addr, o_reg_wr_data, o_reg_wr_strb, o_reg_rd_addr);
    end
    anreset = 1'b1;
    tick();
    vectors++;
    if ({o_awready, o_wready, o_arready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b expected 111", {o_awready, o_wready, o_arready});
    end
  endtask

  task automatic test_aligned_write();
    i_reg_wr_ready = 1;
    i_awaddr = 16'h0010; i_awvalid = 1;
    i_wdata = 64'h1122334455667788; i_wstrb = 8'hFF; i_wvalid = 1;
    tick();
    i_awvalid = 0; i_wvalid = 0;
    vectors++;
    if (o_reg_wr_valid !== 1'b1 || o_reg_wr_addr !== 16'h0010 ||
        o_reg_wr_data !== 64'h1122334455667788 || o_reg_wr_strb !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL aligned_wr_local: valid=%b addr=%h data=%h strb=%h expected 1/0010/1122334455667788/ff",
               o_reg_wr_valid, o_reg_wr_addr, o_reg_wr_data, o_reg_wr_strb);
    end
    vectors++;
    if ({o_awready, o_wready, o_bvalid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL aligned_wr_busy: aw/w/bvalid got %b expected 000", {o_awready, o_wready, o_bvalid});
    end
    tick();
    vectors++;
    if (o_bvalid !== 1'b1 || o_bresp !== 2'b00 || o_reg_wr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL aligned_wr_resp: bvalid=%b bresp=%b wr_valid=%b expected 1/00/0",
               o_bvalid, o_bresp, o_reg_wr_valid);
    end
    i_bready = 1;
    tick();
    i_bready = 0;
    vectors++;
    if ({o_bvalid, o_awready, o_wready} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL aligned_wr_done: bvalid/aw/w got %b expected 011", {o_bvalid, o_awready, o_wready});
    end
  endtask

  task automatic test_w_before_aw();
    i_wdata = 64'hA5A5_0000_FFFF_1234; i_wstrb = 8'h0F; i_wvalid = 1;
    tick();
    i_wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({o_wready, o_awready, o_reg_wr_valid, o_bvalid} !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL w_held_wait%0d: wready/awready/wr_valid/bvalid got %b expected 0100",
                 i, {o_wready, o_awready, o_reg_wr_valid, o_bvalid});
      end
      if (i == 2) begin
        i_awaddr = 16'h0020; i_awvalid = 1;
      end
      tick();
    end
    i_awvalid = 0;
    vectors++;
    if (o_reg_wr_valid !== 1'b1 || o_reg_wr_addr !== 16'h0020 ||
        o_reg_wr_data !== 64'hA5A5_0000_FFFF_1234 || o_reg_wr_strb !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL w_first_local: valid=%b addr=%h data=%h strb=%h expected 1/0020/a5a50000ffff1234/0f",
               o_reg_wr_valid, o_reg_wr_addr, o_reg_wr_data, o_reg_wr_strb);
    end
    tick();
    vectors++;
    if (o_reg_wr_valid !== 1'b0 || o_bvalid !== 1'b1 || o_bresp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL w_first_resp: wr_valid=%b bvalid=%b bresp=%b expected 0/1/00",
               o_reg_wr_valid, o_bvalid, o_bresp);
    end
    i_bready = 1;
    tick();
    i_bready = 0;
    vectors++;
    if (o_bvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL w_first_single: bvalid got %b expected 0", o_bvalid);
    end
  endtask

  task automatic test_misaligned_write();
    i_awaddr = 16'h0013; i_awvalid = 1;
    i_wdata = 64'hFFFF_FFFF_FFFF_FFFF; i_wstrb = 8'hFF; i_wvalid = 1;
    tick();
    i_awvalid = 0; i_wvalid = 0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (o_reg_wr_valid !== 1'b0 || o_bvalid !== 1'b1 || o_bresp !== 2'b10) begin
        errors++;
        $display("[TB] FAIL misaligned_wr%0d: wr_valid=%b bvalid=%b bresp=%b expected 0/1/10",
                 i, o_reg_wr_valid, o_bvalid, o_bresp);
      end
      if (i == 1) i_bready = 1;
      tick();
    end
    i_bready = 0;
    vectors++;
    if (o_bvalid !== 1'b0 || o_reg_wr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misaligned_wr_done: bvalid=%b wr_valid=%b expected 0/0", o_bvalid, o_reg_wr_valid);
    end
  endtask

  task automatic test_read_wait();
    i_araddr = 16'h0040; i_arvalid = 1;
    tick();
    i_arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (o_reg_rd_valid !== 1'b1 || o_reg_rd_addr !== 16'h0040 || o_rvalid !== 1'b0 || o_arready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL read_wait%0d: rd_valid=%b rd_addr=%h rvalid=%b arready=%b expected 1/0040/0/0",
                 i, o_reg_rd_valid, o_reg_rd_addr, o_rvalid, o_arready);
      end
      tick();
    end
    i_reg_rd_ready = 1; i_reg_rd_data = 64'h0000_0000_DEAD_BEEF;
    tick();
    i_reg_rd_ready = 0; i_reg_rd_data = 64'h5555_5555_5555_5555;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (o_rvalid !== 1'b1 || o_rdata !== 64'h0000_0000_DEAD_BEEF || o_rresp !== 2'b00 || o_reg_rd_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL read_hold%0d: rvalid=%b rdata=%h rresp=%b rd_valid=%b expected 1/00000000deadbeef/00/0",
                 i, o_rvalid, o_rdata, o_rresp, o_reg_rd_valid);
      end
      if (i == 4) i_rready = 1;
      tick();
    end
    i_rready = 0;
    vectors++;
    if (o_rvalid !== 1'b0 || o_arready !== 1'b1 || o_reg_rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_done: rvalid=%b arready=%b rd_valid=%b expected 0/1/0", o_rvalid, o_arready, o_reg_rd_valid);
    end
  endtask

  task automatic test_misaligned_read();
    i_araddr = 16'h0005; i_arvalid = 1;
    tick();
    i_arvalid = 0;
    vectors++;
    if (o_rvalid !== 1'b1 || o_rdata !== 64'h0 || o_rresp !== 2'b10 || o_reg_rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misaligned_rd: rvalid=%b rdata=%h rresp=%b rd_valid=%b expected 1/0/10/0",
               o_rvalid, o_rdata, o_rresp, o_reg_rd_valid);
    end
    i_rready = 1;
    tick();
    i_rready = 0;
    vectors++;
    if (o_rvalid !== 1'b0 || o_reg_rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misaligned_rd_done: rvalid=%b rd_valid=%b expected 0/0", o_rvalid, o_reg_rd_valid);
    end
  endtask

  task automatic test_enable();
    aenable = 0;
    tick();
    i_awaddr = 16'h0030; i_awvalid = 1;
    i_wdata = 64'hCAFE_F00D_0BAD_BEEF; i_wstrb = 8'hF0; i_wvalid = 1;
    i_araddr = 16'h0048; i_arvalid = 1;
    i_reg_wr_err = 1; i_reg_rd_ready = 1; i_reg_rd_data = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({o_awready, o_wready, o_arready, o_reg_wr_valid, o_reg_rd_valid, o_bvalid, o_rvalid} !== 7'b0) begin
        errors++;
        $display("[TB] FAIL disabled%0d: aw/w/ar/wrv/rdv/bv/rv got %b expected 0000000",
                 i, {o_awready, o_wready, o_arready, o_reg_wr_valid, o_reg_rd_valid, o_bvalid, o_rvalid});
      end
      tick();
    end
    aenable = 1;
    tick();
    vectors++;
    if ({o_awready, o_wready, o_arready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL enable_ready: got %b expected 111", {o_awready, o_wready, o_arready});
    end
    tick();
    i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
    vectors++;
    if (o_reg_wr_valid !== 1'b1 || o_reg_wr_addr !== 16'h0030 || o_reg_rd_valid !== 1'b1 || o_reg_rd_addr !== 16'h0048) begin
      errors++;
      $display("[TB] FAIL enable_access: wrv=%b waddr=%h rdv=%b raddr=%h expected 1/0030/1/0048",
               o_reg_wr_valid, o_reg_wr_addr, o_reg_rd_valid, o_reg_rd_addr);
    end
    tick();
    vectors++;
    if (o_bvalid !== 1'b1 || o_bresp !== 2'b10 || o_rvalid !== 1'b1 ||
        o_rdata !== 64'h0123_4567_89AB_CDEF || o_rresp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL enable_resp: bvalid=%b bresp=%b rvalid=%b rdata=%h rresp=%b expected 1/10/1/0123456789abcdef/00",
               o_bvalid, o_bresp, o_rvalid, o_rdata, o_rresp);
    end
    i_bready = 1; i_rready = 1;
    i_reg_wr_err = 0; i_reg_rd_ready = 0;
    tick();
    i_bready = 0; i_rready = 0;
    vectors++;
    if ({o_bvalid, o_rvalid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL enable_done: bvalid/rvalid got %b expected 00", {o_bvalid, o_rvalid});
    end
  endtask

  task automatic test_reset_mid_access();
    i_reg_wr_ready = 0;
    i_awaddr = 16'h0050; i_awvalid = 1;
    i_wdata = 64'h1111_2222_3333_4444; i_wstrb = 8'h3C; i_wvalid = 1;
    tick();
    i_awvalid = 0; i_wvalid = 0;
    tick();
    vectors++;
    if (o_reg_wr_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_access_stall: wr_valid got %b expected 1", o_reg_wr_valid);
    end
    anreset = 0;
    tick();
    vectors++;
    if ({o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_reg_wr_valid, o_reg_rd_valid} !== 7'b0 ||
        {o_reg_wr_addr, o_reg_wr_data, o_reg_wr_strb, o_bresp} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset: ctl=%b waddr=%h wdata=%h wstrb=%h bresp=%b expected all 0",
               {o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_reg_wr_valid, o_reg_rd_valid},
               o_reg_wr_addr, o_reg_wr_data, o_reg_wr_strb, o_bresp);
    end
    anreset = 1; i_reg_wr_ready = 1;
    tick();
    vectors++;
    if ({o_bvalid, o_reg_wr_valid, o_awready, o_wready} !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: bv/wrv/aw/w got %b expected 0011", {o_bvalid, o_reg_wr_valid, o_awready, o_wready});
    end
    i_awaddr = 16'h0058; i_awvalid = 1;
    i_wdata = 64'h0F0F_0F0F_0F0F_0F0F; i_wstrb = 8'h81; i_wvalid = 1;
    tick();
    i_awvalid = 0; i_wvalid = 0;
    vectors++;
    if (o_reg_wr_valid !== 1'b1 || o_reg_wr_addr !== 16'h0058 || o_reg_wr_strb !== 8'h81) begin
      errors++;
      $display("[TB] FAIL post_reset_wr: wrv=%b addr=%h strb=%h expected 1/0058/81", o_reg_wr_valid, o_reg_wr_addr, o_reg_wr_strb);
    end
    tick();
    vectors++;
    if (o_bvalid !== 1'b1 || o_bresp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL post_reset_resp: bvalid=%b bresp=%b expected 1/00", o_bvalid, o_bresp);
    end
    i_bready = 1;
    tick();
    i_bready = 0;
  endtask

  initial begin
    test_reset();
    test_aligned_write();
    test_w_before_aw();
    test_misaligned_write();
    test_read_wait();
    test_misaligned_read();
    test_enable();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axil_slv_if.md
Name: axil_slv_if

Overview:
AXI4-Lite responder (subordinate) that terminates AXI-Lite write and read channels and converts them into a simple valid/ready local register-access port. It is the far end of the DMA's AXI-Lite initiator and fronts the DMA configuration/status register bank. Write and read paths are independent FSMs that may run concurrently, with single-outstanding transaction per direction.

Parameters:
ADDR_WIDTH, 16, AXI and local address width in bits
DATA_WIDTH, 64, data width in bits (32 or 64)
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
ALIGN_BITS, $clog2(STRB_WIDTH), low address bits that must be zero for an aligned access

Ports:
aclk  in  1  clock, all logic on rising edge
anreset  in  1  synchronous active-low reset
aenable  in  1  when low, no new AW/W/AR is accepted; in-flight transactions complete
i_awaddr  in  ADDR_WIDTH  write address
i_awprot  in  3  write protection (ignored)
i_awvalid  in  1  write address valid
o_awready  out  1  write address ready
i_wdata  in  DATA_WIDTH  write data
i_wstrb  in  STRB_WIDTH  write byte strobes
i_wvalid  in  1  write data valid
o_wready  out  1  write data ready
o_bresp  out  2  write response (00 OKAY, 10 SLVERR)
o_bvalid  out  1  write response valid
i_bready  in  1  write response ready
i_araddr  in  ADDR_WIDTH  read address
i_arprot  in  3  read protection (ignored)
i_arvalid  in  1  read address valid
o_arready  out  1  read address ready
o_rdata  out  DATA_WIDTH  read data
o_rresp  out  2  read response
o_rvalid  out  1  read data valid
i_rready  in  1  read data ready
o_reg_wr_valid  out  1  local write request
o_reg_wr_addr  out  ADDR_WIDTH  local write address
o_reg_wr_data  out  DATA_WIDTH  local write data
o_reg_wr_strb  out  STRB_WIDTH  local write strobes
i_reg_wr_ready  in  1  local write accepted
i_reg_wr_err  in  1  local write error, sampled with i_reg_wr_ready
o_reg_rd_valid  out  1  local read request
o_reg_rd_addr  out  ADDR_WIDTH  local read address
i_reg_rd_ready  in  1  local read complete, i_reg_rd_data valid
i_reg_rd_data  in  DATA_WIDTH  local read data
i_reg_rd_err  in  1  local read error, sampled with i_reg_rd_ready

Behaviour:
- Reset (anreset=0 at rising edge): all valid/ready outputs 0, o_bresp=o_rresp=0, o_rdata=0, local addr/data/strb 0, both FSMs to IDLE, capture flags cleared; reset mid-transaction abandons it with no response.
- Write FSM W_IDLE/W_ACCESS/W_RESP. In W_IDLE: o_awready = aenable & !aw_held; o_wready = aenable & !w_held; AW and W captured independently into holding regs (any order, or same cycle).
- Cycle after both held: if awaddr[ALIGN_BITS-1:0]==0 go W_ACCESS, else go W_RESP with SLVERR (no local strobe).
- W_ACCESS: o_reg_wr_valid=1, addr/data/strb stable; on i_reg_wr_ready -> W_RESP, bresp = i_reg_wr_err ? SLVERR : OKAY.
- W_RESP: o_bvalid=1, o_bresp stable until i_bready; then clear flags, W_IDLE. awready/wready stay 0 outside W_IDLE.
- Write latency, aligned, zero-wait local: AW&W handshake cycle N -> o_reg_wr_valid N+1 -> o_bvalid N+2.
- Read FSM R_IDLE/R_ACCESS/R_RESP. R_IDLE: o_arready = aenable; on handshake capture address; aligned -> R_ACCESS, misaligned -> R_RESP with rdata=0, SLVERR.
- R_ACCESS: o_reg_rd_valid=1; on i_reg_rd_ready register i_reg_rd_data into o_rdata, rresp from i_reg_rd_err -> R_RESP.
- R_RESP: o_rvalid=1, o_rdata/o_rresp stable until i_rready; then R_IDLE. Read latency: AR cycle N -> rd_valid N+1 -> rvalid N+2.
- Write and read paths concurrent; local ports are separate, no arbitration.
- aenable falling mid-transaction: ready outputs drop next evaluation; ACCESS/RESP states still complete.
- All outputs registered; no combinational path from any AXI input to any AXI output.

Test Plan:
- AW addr 0x0010 and W data 0x1122334455667788 strb 0xFF same cycle, reg_wr_ready tied 1 -> reg_wr at N+1 with matching addr/data/strb, bvalid N+2 bresp=00.
- W presented 3 cycles before AW (addr 0x0020) -> W held, wready low after capture, single local write at AW+1, one OKAY response.
- Misaligned write addr 0x0013 -> no o_reg_wr_valid ever, bvalid with bresp=10; misaligned read 0x0005 -> rvalid, rdata=0, rresp=10.
- Read addr 0x0040, reg_rd_ready after 4 wait cycles with data 0xDEADBEEF, i_rready held low 5 cycles -> rvalid stays 1, rdata stable, single transfer.
- aenable=0 with AW/W/AR pending -> all readys 0, no activity; raise aenable -> transactions complete normally; i_reg_wr_err=1 -> bresp=10.
- Assert anreset mid W_ACCESS -> next cycle all outputs at reset values, no bvalid; new write afterward completes OKAY.
